// File: rtl/vpu_src_burst_port_ctrl.sv
// vpu_src_burst_port_ctrl: issues a 1..MAX_BURST beat bank-interleaved SRAM read burst,
// limited by outstanding reads and operand-queue credit, and streams returned data into the queue.
module vpu_src_burst_port_ctrl #(
  parameter int BANK_CNT_LG2 = 2,
  parameter int BANK_DEPTH_LG2 = 10,
  parameter int DATA_WIDTH = 256,
  parameter int MAX_BURST = 8,
  parameter int MAX_OUTSTANDING = 4,
  parameter int QFREE_WIDTH = 5,
  localparam int ADDR_WIDTH = BANK_CNT_LG2 + BANK_DEPTH_LG2,
  localparam int LEN_WIDTH = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1,
  localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      rvalid_i,
  input  logic [ADDR_WIDTH-1:0]     raddr_i,
  input  logic [LEN_WIDTH-1:0]      len_i,
  input  logic                      reset_cmd_i,
  output logic                      done_o,
  output logic                      err_o,
  output logic [DATA_WIDTH-1:0]     wdata_o,
  output logic                      wren_o,
  input  logic [QFREE_WIDTH-1:0]    wrfree_i,
  input  logic                      wrfull_i,
  output logic                      sram_req_o,
  output logic [BANK_CNT_LG2-1:0]   sram_rid_o,
  output logic [BANK_DEPTH_LG2-1:0] sram_addr_o,
  output logic                      sram_reb_o,
  output logic                      sram_rlast_o,
  input  logic                      sram_ack_i,
  input  logic                      sram_rvalid_i,
  input  logic [DATA_WIDTH-1:0]     sram_rdata_i
);
  localparam int BW = LEN_WIDTH + 1;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t                    r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0]     r_addr, w_base;
  logic [LEN_WIDTH-1:0]      r_len, w_len;
  logic [BW-1:0]             r_iss_cnt, r_ret_cnt, r_lnc_cnt, w_lnc, w_total, w_ret_nxt;
  logic [CNT_WIDTH-1:0]      r_out_cnt, w_eff;
  logic                      r_req, r_reb, r_rlast, r_err;
  logic [BANK_CNT_LG2-1:0]   r_rid;
  logic [BANK_DEPTH_LG2-1:0] r_raddr;
  logic                      w_idle, w_start, w_ret, w_ack, w_room, w_launch, w_last_ack, w_clr, w_err;

  // In IDLE the request inputs stand in for the latched burst so beat 0 can launch immediately.
  always_comb begin
    w_idle     = r_state == S_IDLE;
    w_start    = w_idle && valid_i && rvalid_i;
    w_base     = w_idle ? raddr_i : r_addr;
    w_len      = w_idle ? len_i : r_len;
    w_lnc      = w_idle ? '0 : r_lnc_cnt;
    w_total    = BW'(w_len) + BW'(1);
    w_ret      = sram_rvalid_i && r_out_cnt != '0;
    wren_o     = w_ret && (r_state == S_ISSUE || r_state == S_DRAIN);
    wdata_o    = sram_rdata_i;
    w_eff      = r_out_cnt - CNT_WIDTH'(w_ret);
    w_room     = int'(w_eff) < MAX_OUTSTANDING && int'(w_eff) < int'(wrfree_i);
    w_ack      = r_req && sram_ack_i;
    w_launch   = w_room && w_lnc < w_total && (w_start || (r_state == S_ISSUE && (!r_req || w_ack)));
    w_last_ack = w_ack && r_iss_cnt == BW'(r_len);
    w_ret_nxt  = r_ret_cnt + BW'(wren_o);
    w_clr      = r_state == S_DONE && reset_cmd_i;
    w_err      = (sram_rvalid_i && r_out_cnt == '0) || (wren_o && wrfull_i) || (sram_ack_i && !r_req);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  w_state_nxt = valid_i ? (rvalid_i ? S_ISSUE : S_DONE) : S_IDLE;
      S_ISSUE: w_state_nxt = w_last_ack ? S_DRAIN : S_ISSUE;
      S_DRAIN: w_state_nxt = w_ret_nxt == w_total ? S_DONE : S_DRAIN;
      S_DONE:  w_state_nxt = reset_cmd_i ? S_IDLE : S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_iss_cnt <= '0;
      r_ret_cnt <= '0;
      r_lnc_cnt <= '0;
      r_out_cnt <= '0;
      r_err     <= 1'b0;
      r_req     <= 1'b0;
      r_reb     <= 1'b1;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_raddr   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_err     <= !w_clr && (r_err || w_err);
      r_out_cnt <= w_clr ? '0 : r_out_cnt + CNT_WIDTH'(w_launch) - CNT_WIDTH'(w_ret);
      r_iss_cnt <= w_clr ? '0 : r_iss_cnt + BW'(w_ack);
      r_ret_cnt <= w_clr ? '0 : w_ret_nxt;
      r_lnc_cnt <= w_clr ? '0 : w_lnc + BW'(w_launch);
      if (w_start) r_len <= len_i;
      if (w_start || w_launch) r_addr <= w_base + ADDR_WIDTH'(w_launch);
      if (w_launch) begin
        r_req   <= 1'b1;
        r_reb   <= 1'b0;
        r_rid   <= w_base[BANK_CNT_LG2-1:0];
        r_raddr <= w_base[ADDR_WIDTH-1:BANK_CNT_LG2];
        r_rlast <= w_lnc == BW'(w_len);
      end else if (w_ack) begin
        r_req   <= 1'b0;
        r_reb   <= 1'b1;
        r_rlast <= 1'b0;
      end
    end
  end

  assign ready_o      = r_state == S_IDLE;
  assign done_o       = r_state == S_DONE;
  assign err_o        = r_err;
  assign sram_req_o   = r_req;
  assign sram_reb_o   = r_reb;
  assign sram_rlast_o = r_rlast;
  assign sram_rid_o   = r_rid;
  assign sram_addr_o  = r_raddr;
endmodule

// File: tb/tb_vpu_src_burst_port_ctrl.sv
// tb_vpu_src_burst_port_ctrl: directed cycle-by-cycle checks of burst issue, credit stall,
// ack backpressure, no-read requests, error flagging and async reset.
module tb_vpu_src_burst_port_ctrl;
  localparam int AW = 12;
  localparam int DW = 256;
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           valid_i = 1'b0, rvalid_i = 1'b0, reset_cmd_i = 1'b0, wrfull_i = 1'b0;
  logic           sram_ack_i = 1'b0, sram_rvalid_i = 1'b0;
  logic [AW-1:0]  raddr_i = '0;
  logic [2:0]     len_i = '0;
  logic [4:0]     wrfree_i = 5'd8;
  logic [DW-1:0]  sram_rdata_i = '0;
  logic           ready_o, done_o, err_o, wren_o, sram_req_o, sram_reb_o, sram_rlast_o;
  logic [DW-1:0]  wdata_o;
  logic [1:0]     sram_rid_o;
  logic [9:0]     sram_addr_o;
  int             n_vec = 0, n_err = 0;

  vpu_src_burst_port_ctrl dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .ready_o(ready_o), .rvalid_i(rvalid_i),
    .raddr_i(raddr_i), .len_i(len_i), .reset_cmd_i(reset_cmd_i), .done_o(done_o), .err_o(err_o),
    .wdata_o(wdata_o), .wren_o(wren_o), .wrfree_i(wrfree_i), .wrfull_i(wrfull_i),
    .sram_req_o(sram_req_o), .sram_rid_o(sram_rid_o), .sram_addr_o(sram_addr_o),
    .sram_reb_o(sram_reb_o), .sram_rlast_o(sram_rlast_o), .sram_ack_i(sram_ack_i),
    .sram_rvalid_i(sram_rvalid_i), .sram_rdata_i(sram_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (sram_req_o !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b want 0", sram_req_o); end
    n_vec++; if (sram_reb_o !== 1'b1) begin n_err++; $display("FAIL rst_reb: got %b want 1", sram_reb_o); end
    n_vec++; if ({sram_addr_o, sram_rid_o, sram_rlast_o} !== 13'h0) begin n_err++; $display("FAIL rst_addr: got %h want 0", {sram_addr_o, sram_rid_o, sram_rlast_o}); end
    n_vec++; if ({ready_o, done_o, err_o, wren_o} !== 4'b1000) begin n_err++; $display("FAIL rst_ctrl: got %b want 1000", {ready_o, done_o, err_o, wren_o}); end
    rst_n = 1'b1;
  endtask

  task automatic test_single_beat();
    cyc(); valid_i = 1; rvalid_i = 1; raddr_i = 12'h005; len_i = 0; #1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL sb_ready: got %b want 1", ready_o); end
    cyc(); valid_i = 0; sram_ack_i = 1; #1;
    n_vec++; if ({sram_req_o, sram_reb_o, sram_rlast_o} !== 3'b101) begin n_err++; $display("FAIL sb_req: got %b want 101", {sram_req_o, sram_reb_o, sram_rlast_o}); end
    n_vec++; if ({sram_addr_o, sram_rid_o} !== 12'h005) begin n_err++; $display("FAIL sb_addr: got %h want 005", {sram_addr_o, sram_rid_o}); end
    cyc(); sram_ack_i = 0; #1;
    n_vec++; if ({sram_req_o, sram_rlast_o} !== 2'b00) begin n_err++; $display("FAIL sb_req_drop: got %b want 00", {sram_req_o, sram_rlast_o}); end
    cyc(); sram_rvalid_i = 1; sram_rdata_i = {8{32'h1234_5678}}; #1;
    n_vec++; if (wren_o !== 1'b1 || wdata_o !== {8{32'h1234_5678}}) begin n_err++; $display("FAIL sb_wren: got %b/%h want 1/12345678..", wren_o, wdata_o[31:0]); end
    cyc(); sram_rvalid_i = 0; #1;
    n_vec++; if ({done_o, wren_o, err_o} !== 3'b100) begin n_err++; $display("FAIL sb_done: got %b want 100", {done_o, wren_o, err_o}); end
    reset_cmd_i = 1;
    cyc(); reset_cmd_i = 0; #1;
    n_vec++; if ({ready_o, done_o} !== 2'b10) begin n_err++; $display("FAIL sb_rearm: got %b want 10", {ready_o, done_o}); end
  endtask

  task automatic test_burst_rotation();
    logic [0:9]    ack_v = 10'b0111100000;
    logic [0:9]    rv_v  = 10'b0000011110;
    logic [0:9]    lst_v = 10'b0000100000;
    logic [AW-1:0] beat [4] = '{12'h00E, 12'h00F, 12'h010, 12'h011};
    logic [DW-1:0] d;
    int            nb = 0, nr = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      d = {8{32'hB000_0000 | 32'(nr)}};
      valid_i = c == 0; rvalid_i = 1; raddr_i = 12'h00E; len_i = 3;
      sram_ack_i = ack_v[c]; sram_rvalid_i = rv_v[c]; sram_rdata_i = d; reset_cmd_i = c == 9;
      #1;
      n_vec++; if (sram_req_o !== ack_v[c] || sram_reb_o !== !ack_v[c]) begin n_err++; $display("FAIL rot_req c%0d: got %b%b want %b", c, sram_req_o, sram_reb_o, ack_v[c]); end
      n_vec++; if (sram_rlast_o !== lst_v[c]) begin n_err++; $display("FAIL rot_rlast c%0d: got %b want %b", c, sram_rlast_o, lst_v[c]); end
      n_vec++; if (wren_o !== rv_v[c]) begin n_err++; $display("FAIL rot_wren c%0d: got %b want %b", c, wren_o, rv_v[c]); end
      n_vec++; if (done_o !== (c == 9)) begin n_err++; $display("FAIL rot_done c%0d: got %b", c, done_o); end
      if (ack_v[c]) begin
        n_vec++; if ({sram_addr_o, sram_rid_o} !== beat[nb]) begin n_err++; $display("FAIL rot_addr c%0d: got %h want %h", c, {sram_addr_o, sram_rid_o}, beat[nb]); end
        nb++;
      end
      if (rv_v[c]) begin
        n_vec++; if (wdata_o !== d) begin n_err++; $display("FAIL rot_wdata c%0d: got %h want %h", c, wdata_o[31:0], d[31:0]); end
        nr++;
      end
    end
    cyc(); valid_i = 0; reset_cmd_i = 0; sram_ack_i = 0; sram_rvalid_i = 0; #1;
    n_vec++; if ({ready_o, err_o} !== 2'b10) begin n_err++; $display("FAIL rot_end: got %b want 10", {ready_o, err_o}); end
  endtask

  task automatic test_credit_stall();
    logic [0:20]   ack_v = 21'b011000011000011000000;
    logic [0:20]   rv_v  = 21'b000000110000110000110;
    logic [0:20]   lst_v = 21'b000000000000001000000;
    logic [AW-1:0] beat [6] = '{12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025};
    int            nb = 0;
    wrfree_i = 5'd2;
    for (int c = 0; c < 21; c++) begin
      cyc();
      valid_i = c == 0; rvalid_i = 1; raddr_i = 12'h020; len_i = 5;
      sram_ack_i = ack_v[c]; sram_rvalid_i = rv_v[c]; sram_rdata_i = '0; reset_cmd_i = c == 20;
      #1;
      n_vec++; if (sram_req_o !== ack_v[c]) begin n_err++; $display("FAIL cr_req c%0d: got %b want %b", c, sram_req_o, ack_v[c]); end
      n_vec++; if (sram_rlast_o !== lst_v[c]) begin n_err++; $display("FAIL cr_rlast c%0d: got %b want %b", c, sram_rlast_o, lst_v[c]); end
      n_vec++; if (wren_o !== rv_v[c]) begin n_err++; $display("FAIL cr_wren c%0d: got %b want %b", c, wren_o, rv_v[c]); end
      n_vec++; if (done_o !== (c == 20)) begin n_err++; $display("FAIL cr_done c%0d: got %b", c, done_o); end
      if (ack_v[c]) begin
        n_vec++; if ({sram_addr_o, sram_rid_o} !== beat[nb]) begin n_err++; $display("FAIL cr_addr c%0d: got %h want %h", c, {sram_addr_o, sram_rid_o}, beat[nb]); end
        nb++;
      end
    end
    n_vec++; if (err_o !== 1'b0) begin n_err++; $display("FAIL cr_err: got %b want 0", err_o); end
    cyc(); valid_i = 0; reset_cmd_i = 0; sram_ack_i = 0; sram_rvalid_i = 0; wrfree_i = 5'd8; #1;
    n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL cr_end: got %b want 1", ready_o); end
  endtask

  task automatic test_ack_backpressure();
    logic [0:9]    ack_v = 10'b0000110000;
    logic [0:9]    req_v = 10'b0111110000;
    logic [0:9]    rv_v  = 10'b0000000110;
    logic [0:9]    lst_v = 10'b0000010000;
    logic [AW-1:0] beat [2] = '{12'hFFF, 12'h000};
    int            nb = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      valid_i = c == 0; rvalid_i = 1; raddr_i = 12'hFFF; len_i = 1;
      sram_ack_i = ack_v[c]; sram_rvalid_i = rv_v[c]; reset_cmd_i = c == 9;
      #1;
      n_vec++; if (sram_req_o !== req_v[c]) begin n_err++; $display("FAIL bp_req c%0d: got %b want %b", c, sram_req_o, req_v[c]); end
      n_vec++; if (sram_rlast_o !== lst_v[c]) begin n_err++; $display("FAIL bp_rlast c%0d: got %b want %b", c, sram_rlast_o, lst_v[c]); end
      n_vec++; if (wren_o !== rv_v[c]) begin n_err++; $display("FAIL bp_wren c%0d: got %b want %b", c, wren_o, rv_v[c]); end
      n_vec++; if (done_o !== (c == 9)) begin n_err++; $display("FAIL bp_done c%0d: got %b", c, done_o); end
      if (req_v[c]) begin
        n_vec++; if ({sram_addr_o, sram_rid_o} !== beat[nb]) begin n_err++; $display("FAIL bp_addr c%0d: got %h want %h", c, {sram_addr_o, sram_rid_o}, beat[nb]); end
        if (ack_v[c]) nb++;
      end
    end
    cyc(); valid_i = 0; reset_cmd_i = 0; sram_ack_i = 0; sram_rvalid_i = 0; #1;
    n_vec++; if ({ready_o, err_o} !== 2'b10) begin n_err++; $display("FAIL bp_end: got %b want 10", {ready_o, err_o}); end
  endtask

  task automatic test_no_read();
    cyc(); valid_i = 1; rvalid_i = 0; #1;
    n_vec++; if (wren_o !== 1'b0) begin n_err++; $display("FAIL nr_wren: got %b want 0", wren_o); end
    cyc(); valid_i = 0; #1;
    n_vec++; if ({done_o, sram_req_o, wren_o} !== 3'b100) begin n_err++; $display("FAIL nr_done: got %b want 100", {done_o, sram_req_o, wren_o}); end
    reset_cmd_i = 1;
    cyc(); reset_cmd_i = 0; #1;
    n_vec++; if ({ready_o, done_o} !== 2'b10) begin n_err++; $display("FAIL nr_rearm: got %b want 10", {ready_o, done_o}); end
  endtask

  task automatic test_errors_reset();
    cyc(); sram_rvalid_i = 1; #1;
    n_vec++; if (wren_o !== 1'b0) begin n_err++; $display("FAIL er_spur_wren: got %b want 0", wren_o); end
    cyc(); sram_rvalid_i = 0; #1;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL er_spur_rv: got %b want 1", err_o); end
    valid_i = 1; rvalid_i = 0;
    cyc(); valid_i = 0; #1;
    n_vec++; if ({done_o, err_o} !== 2'b11) begin n_err++; $display("FAIL er_sticky: got %b want 11", {done_o, err_o}); end
    reset_cmd_i = 1;
    cyc(); reset_cmd_i = 0; #1;
    n_vec++; if ({ready_o, err_o} !== 2'b10) begin n_err++; $display("FAIL er_clear: got %b want 10", {ready_o, err_o}); end
    sram_ack_i = 1;
    cyc(); sram_ack_i = 0; #1;
    n_vec++; if (err_o !== 1'b1) begin n_err++; $display("FAIL er_spur_ack: got %b want 1", err_o); end
    valid_i = 1; rvalid_i = 1; raddr_i = 12'h100; len_i = 3;
    cyc(); valid_i = 0; sram_ack_i = 1; #1;
    n_vec++; if ({sram_req_o, sram_addr_o, sram_rid_o} !== 13'h1100) begin n_err++; $display("FAIL er_beat0: got %h want 1100", {sram_req_o, sram_addr_o, sram_rid_o}); end
    cyc(); sram_ack_i = 0; #1;
    n_vec++; if ({sram_req_o, sram_addr_o, sram_rid_o} !== 13'h1101) begin n_err++; $display("FAIL er_beat1: got %h want 1101", {sram_req_o, sram_addr_o, sram_rid_o}); end
    rst_n = 0; #1;
    n_vec++; if ({sram_req_o, sram_reb_o, sram_rlast_o, sram_addr_o, sram_rid_o} !== 15'h2000) begin n_err++; $display("FAIL er_arst_sram: got %h want 2000", {sram_req_o, sram_reb_o, sram_rlast_o, sram_addr_o, sram_rid_o}); end
    n_vec++; if ({ready_o, done_o, err_o, wren_o} !== 4'b1000) begin n_err++; $display("FAIL er_arst_ctrl: got %b want 1000", {ready_o, done_o, err_o, wren_o}); end
    cyc(); rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_burst_rotation();
    test_credit_stall();
    test_ack_backpressure();
    test_no_read();
    test_errors_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
